// File: rtl/uart_tx.sv
// uart_tx: 8N1/8E1/8O1 UART transmitter with an internal prescale counter.
// Ports: clk, rst (sync, active-high), P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
//   Prescale (clk cycles per bit, 0 acts as 1), TX_OUT (idles high), busy.
// Optional macro UART_TX_HOLD_EN adds a one-entry holding register; busy
//   then reports "holding register full" and frames chain with no gap.
module uart_tx #(
  parameter int DATA_WIDTH  = 8,
  parameter int PRESC_WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  P_DATA,
  input  logic                   DATA_VALID,
  input  logic                   PAR_EN,
  input  logic                   PAR_TYP,
  input  logic [PRESC_WIDTH-1:0] Prescale,
  output logic                   TX_OUT,
  output logic                   busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam logic [2:0] IDX_LAST = 3'(DATA_WIDTH - 1);

  state_t                  state_q, state_d;
  logic [PRESC_WIDTH-1:0]  cnt_q, cnt_d;
  logic [2:0]              idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   sh_q, sh_d;
  logic                    pen_q, pen_d;
  logic                    pbit_q, pbit_d;
  logic [PRESC_WIDTH-1:0]  p_q, p_d;
  logic                    tx_q, tx_d;
  logic                    busy_q, busy_d;

  logic [PRESC_WIDTH-1:0]  in_p;
  logic                    in_pbit;
  logic                    cnt_last;
  logic                    accept;
  logic                    load_in;

`ifdef UART_TX_HOLD_EN
  logic [DATA_WIDTH-1:0]   h_data_q, h_data_d;
  logic                    h_pen_q, h_pen_d;
  logic                    h_pbit_q, h_pbit_d;
  logic [PRESC_WIDTH-1:0]  h_p_q, h_p_d;
  logic                    hold_full_q, hold_full_d;
  logic                    load_hold;
  logic                    engine_free;
`endif

  // Zero prescale behaves as one cycle per bit.
  assign in_p     = (Prescale == '0) ? PRESC_WIDTH'(1) : Prescale;
  // Even: bit = ^data. Odd: bit = ~^data.
  assign in_pbit  = (^P_DATA) ^ PAR_TYP;
  assign cnt_last = (cnt_q == p_q - 1'b1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    pen_d   = pen_q;
    pbit_d  = pbit_q;
    p_d     = p_q;
    load_in = 1'b0;
    accept  = 1'b0;
`ifdef UART_TX_HOLD_EN
    h_data_d    = h_data_q;
    h_pen_d     = h_pen_q;
    h_pbit_d    = h_pbit_q;
    h_p_d       = h_p_q;
    hold_full_d = hold_full_q;
    load_hold   = 1'b0;
    engine_free = 1'b0;
`endif

    if (state_q != S_IDLE) begin
      if (cnt_last) begin
        cnt_d = '0;
        unique case (state_q)
          S_START: begin
            state_d = S_DATA;
            idx_d   = '0;
          end
          S_DATA: begin
            if (idx_q == IDX_LAST) begin
              state_d = pen_q ? S_PARITY : S_STOP;
            end else begin
              idx_d = idx_q + 1'b1;
              sh_d  = sh_q >> 1;
            end
          end
          S_PARITY: state_d = S_STOP;
          S_STOP:   state_d = S_IDLE;
          default:  state_d = S_IDLE;
        endcase
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

`ifdef UART_TX_HOLD_EN
    accept = DATA_VALID && !hold_full_q;
    // The engine can take a new word when idle or on the edge ending STOP.
    engine_free = (state_q == S_IDLE) ||
                  (state_q == S_STOP && cnt_last);
    if (engine_free) begin
      if (hold_full_q) begin
        load_hold = 1'b1;
      end else if (accept) begin
        load_in = 1'b1;
      end
    end else if (accept) begin
      h_data_d    = P_DATA;
      h_pen_d     = PAR_EN;
      h_pbit_d    = in_pbit;
      h_p_d       = in_p;
      hold_full_d = 1'b1;
    end
    if (load_hold) begin
      state_d     = S_START;
      cnt_d       = '0;
      idx_d       = '0;
      sh_d        = h_data_q;
      pen_d       = h_pen_q;
      pbit_d      = h_pbit_q;
      p_d         = h_p_q;
      hold_full_d = 1'b0;
    end
`else
    accept = DATA_VALID && !busy_q;
    if (state_q == S_IDLE && accept) begin
      load_in = 1'b1;
    end
`endif

    if (load_in) begin
      state_d = S_START;
      cnt_d   = '0;
      idx_d   = '0;
      sh_d    = P_DATA;
      pen_d   = PAR_EN;
      pbit_d  = in_pbit;
      p_d     = in_p;
    end

    // Outputs are registered: derive them from the next state.
    tx_d = 1'b1;
    unique case (state_d)
      S_IDLE:   tx_d = 1'b1;
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = sh_d[0];
      S_PARITY: tx_d = pbit_d;
      S_STOP:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase

`ifdef UART_TX_HOLD_EN
    busy_d = hold_full_d;
`else
    busy_d = (state_d != S_IDLE);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      pen_q   <= 1'b0;
      pbit_q  <= 1'b0;
      p_q     <= PRESC_WIDTH'(1);
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
`ifdef UART_TX_HOLD_EN
      h_data_q    <= '0;
      h_pen_q     <= 1'b0;
      h_pbit_q    <= 1'b0;
      h_p_q       <= PRESC_WIDTH'(1);
      hold_full_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      pen_q   <= pen_d;
      pbit_q  <= pbit_d;
      p_q     <= p_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
`ifdef UART_TX_HOLD_EN
      h_data_q    <= h_data_d;
      h_pen_q     <= h_pen_d;
      h_pbit_q    <= h_pbit_d;
      h_p_q       <= h_p_d;
      hold_full_q <= hold_full_d;
`endif
    end
  end

  assign TX_OUT = tx_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized self-checking bench for uart_tx.
// Expected line levels come from a frame-bit list model sampled per cycle.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] Prescale;
  logic       TX_OUT;
  logic       busy;

  int total = 0;
  int bad   = 0;

  bit exp_q[$];

`ifdef UART_TX_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  uart_tx dut (
    .clk        (clk),
    .rst        (rst),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .Prescale   (Prescale),
    .TX_OUT     (TX_OUT),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Appends one frame's line levels (one entry per bit period).
  function automatic void add_frame(input logic [7:0] d,
                                    input logic pen,
                                    input logic ptyp);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(((d >> i) & 1) != 0);
    if (pen) exp_q.push_back((($countones(d) % 2) ^ ptyp) != 0);
    exp_q.push_back(1'b1);
  endfunction

  // Called at a negedge with the line idle; returns at a negedge, idle.
  task automatic run_frame(input logic [7:0] d, input logic pen,
                           input logic ptyp, input logic [5:0] presc,
                           input int inj, input string name);
    int p;
    int n;
    p = (presc == 0) ? 1 : int'(presc);
    exp_q.delete();
    add_frame(d, pen, ptyp);
    n = exp_q.size() * p;
    P_DATA = d; PAR_EN = pen; PAR_TYP = ptyp; Prescale = presc;
    DATA_VALID = 1'b1;
    @(negedge clk);
    DATA_VALID = 1'b0;
    P_DATA = 8'($urandom); PAR_EN = ~pen;
    PAR_TYP = 1'($urandom); Prescale = 6'($urandom);
    for (int k = 0; k < n; k++) begin
      if (k == inj) begin
        DATA_VALID = 1'b1;
        P_DATA = 8'hFF;
      end else begin
        DATA_VALID = 1'b0;
      end
      total++;
      if (TX_OUT !== exp_q[k / p] || busy !== !HOLD) begin
        bad++;
        $display("FAIL %s k=%0d tx=%b busy=%b want tx=%b busy=%b",
                 name, k, TX_OUT, busy, exp_q[k / p], !HOLD);
      end
      @(negedge clk);
    end
    DATA_VALID = 1'b0;
    total++;
    if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_end tx=%b busy=%b want tx=1 busy=0",
               name, TX_OUT, busy);
    end
  endtask

  task automatic check_idle(input int cycles, input string name);
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      total++;
      if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
        bad++;
        $display("FAIL %s k=%0d tx=%b busy=%b want tx=1 busy=0",
                 name, k, TX_OUT, busy);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    DATA_VALID = 1'b1;
    P_DATA = 8'h5A; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 6'd3;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
        bad++;
        $display("FAIL reset k=%0d tx=%b busy=%b want tx=1 busy=0",
                 k, TX_OUT, busy);
      end
    end
    rst = 1'b0;
    DATA_VALID = 1'b0;
    check_idle(2, "post_reset");
  endtask

  task automatic test_basic();
    run_frame(8'h45, 1'b0, 1'b0, 6'd8, -1, "frame_45");
  endtask

  task automatic test_parity();
    run_frame(8'hAA, 1'b1, 1'b0, 6'd8, -1, "par_AA_even");
    run_frame(8'hA8, 1'b1, 1'b1, 6'd8, -1, "par_A8_odd");
    run_frame(8'hA8, 1'b1, 1'b0, 6'd8, -1, "par_A8_even");
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++) begin
      run_frame(8'($urandom), 1'($urandom), 1'($urandom),
                6'($urandom_range(0, 12)), -1, "random");
    end
  endtask

  task automatic test_ignore();
    run_frame(8'h55, 1'b0, 1'b0, 6'd4, 9, "ignore_busy");
    check_idle(6, "ignore_after");
  endtask

  task automatic test_reset_mid();
    exp_q.delete();
    add_frame(8'h00, 1'b0, 1'b0);
    P_DATA = 8'h00; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 6'd16;
    DATA_VALID = 1'b1;
    @(negedge clk);
    DATA_VALID = 1'b0;
    for (int k = 0; k < 50; k++) begin
      total++;
      if (TX_OUT !== exp_q[k / 16] || busy !== !HOLD) begin
        bad++;
        $display("FAIL pre_rst k=%0d tx=%b busy=%b want tx=%b",
                 k, TX_OUT, busy, exp_q[k / 16]);
      end
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset tx=%b busy=%b want tx=1 busy=0",
               TX_OUT, busy);
    end
    rst = 1'b0;
    check_idle(3, "after_mid_reset");
    run_frame(8'h3C, 1'b0, 1'b0, 6'd5, -1, "frame_3C");
  endtask

  task automatic test_min_presc();
    run_frame(8'h81, 1'b0, 1'b0, 6'd0, -1, "presc0");
    run_frame(8'h81, 1'b0, 1'b0, 6'd1, -1, "presc1");
  endtask

  task automatic test_back_to_back();
    run_frame(8'hC3, 1'b1, 1'b1, 6'd3, -1, "b2b_a");
    run_frame(8'h3C, 1'b0, 1'b0, 6'd2, -1, "b2b_b");
    run_frame(8'h81, 1'b0, 1'b0, 6'd1, -1, "b2b_c");
  endtask

  task automatic test_hold();
    exp_q.delete();
    add_frame(8'h81, 1'b0, 1'b0);
    add_frame(8'h7E, 1'b0, 1'b0);
    P_DATA = 8'h81; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 6'd1;
    DATA_VALID = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      if (k == 0) begin
        P_DATA = 8'h7E;
        DATA_VALID = 1'b1;
      end else begin
        DATA_VALID = 1'b0;
      end
      total++;
      if (TX_OUT !== exp_q[k]) begin
        bad++;
        $display("FAIL hold k=%0d tx=%b want %b", k, TX_OUT, exp_q[k]);
      end
      if (k == 1) begin
        total++;
        if (busy !== 1'b1) begin
          bad++;
          $display("FAIL hold_busy busy=%b want 1", busy);
        end
      end
      @(negedge clk);
    end
    DATA_VALID = 1'b0;
    check_idle(3, "hold_after");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_random();
`ifdef UART_TX_HOLD_EN
    test_hold();
`else
    test_ignore();
`endif
    test_reset_mid();
    test_min_presc();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter, the transmit-side counterpart of the team's UART receiver. It serialises one 8-bit word per frame: start bit, 8 data bits LSB first, optional parity bit, stop bit. It runs on the system clock and uses an internal prescale counter that sets the bit period. Its TX_OUT frame format is bit-compatible with the receiver's RX_IN, including the PAR_TYP encoding.

Parameters:
DATA_WIDTH, 8, payload bits per frame (fixed at 8 for this revision; other values are not supported)
PRESC_WIDTH, 6, width of the Prescale input

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, synchronous, active-high
P_DATA  in  8  word to transmit, sampled on acceptance
DATA_VALID  in  1  request to send P_DATA
PAR_EN  in  1  1 = include a parity bit
PAR_TYP  in  1  0 = even parity (parity bit = ^data), 1 = odd parity (parity bit = ~^data)
Prescale  in  6  clk cycles per bit; 0 is treated as 1
TX_OUT  out  1  serial line; idles high
busy  out  1  high while a frame is in progress

Behaviour:
- Reset: synchronous and active-high, sampled on the rising clk edge. On reset, state = IDLE, TX_OUT = 1, busy = 0, all counters = 0, and the shift register is cleared. Reset overrides any frame in progress; the line returns high on the same edge.
- Acceptance: at a rising edge where DATA_VALID = 1 and busy = 0 (registered value), the block latches P_DATA, PAR_EN, PAR_TYP and Prescale. Changes to these inputs after that edge do not affect the current frame.
- A DATA_VALID pulse while busy = 1 is ignored, not queued (without the optional feature).
- Latency: TX_OUT falls to 0 and busy rises to 1 on the acceptance edge itself. Both outputs are registered and are never combinational from inputs.
- States:
  - IDLE: TX_OUT = 1.
  - START: TX_OUT = 0.
  - DATA: TX_OUT = data[idx], idx 0..7.
  - PARITY: TX_OUT = parity bit.
  - STOP: TX_OUT = 1.
- Transitions:
  - IDLE to START on acceptance.
  - Each non-IDLE state holds for exactly P = max(Prescale_latched, 1) cycles, timed by a prescale counter counting 0..P-1.
  - START to DATA.
  - DATA to DATA while idx < 7; DATA to PARITY if PAR_EN, else to STOP.
  - PARITY to STOP.
  - STOP to IDLE.
- busy falls on the edge that ends the STOP bit; TX_OUT stays 1.
- Frame length: (10 + PAR_EN) × P cycles, from the acceptance edge to the edge where busy falls.
- Back-to-back frames: the next acceptance can occur one edge after busy falls, so the stop bit is effectively P + 1 cycles. Without the optional feature, no frame ever has a stop bit shorter than P cycles.
- The parity bit is computed from the latched data, not the live P_DATA.
- The prescale counter and bit index wrap to 0 at each bit boundary and never overflow; P = 63 is the maximum.

Optional Feature:
UART_TX_HOLD_EN. When defined, the block adds a one-entry holding register (data plus the latched configuration) and a hold_full flag.
- DATA_VALID is accepted whenever hold_full = 0, including while busy = 1.
- busy then means "the holding register is full"; the frame engine keeps an internal active flag.
- When a frame's STOP bit ends and the holding register is full, START of the next frame begins on the very next cycle, with no extra idle cycle. The stop bit is exactly P cycles.
- Reset clears hold_full.
When the macro is undefined, behaviour is exactly as described in Behaviour and there is no holding register.

Test Plan:
- rst = 1 for 2 cycles, then DATA_VALID = 1 during reset -> TX_OUT = 1 and busy = 0 throughout; no frame starts.
- P_DATA = 0x45, PAR_EN = 0, Prescale = 8 -> TX_OUT sampled mid-bit reads 0,1,0,1,0,0,0,1,0,1; busy is high for exactly 80 cycles.
- P_DATA = 0xAA, PAR_EN = 1, PAR_TYP = 0, Prescale = 8 -> parity bit = 0; frame is 88 cycles. Repeat with 0xA8, PAR_TYP = 1 -> parity bit = 0; with 0xA8, PAR_TYP = 0 -> parity bit = 1.
- Start 0x55 at Prescale = 4, then pulse DATA_VALID with 0xFF at cycle 10 -> 0xFF is never sent; the line returns to idle after 40 cycles.
- Start 0x00 at Prescale = 16, assert rst at cycle 50 -> TX_OUT = 1 and busy = 0 on the next edge; a following 0x3C frame is sent correctly.
- Prescale = 0 and Prescale = 1 with 0x81 -> each bit lasts 1 cycle; frame is 10 cycles. With UART_TX_HOLD_EN, two back-to-back words give 20 contiguous cycles with no gap.
